// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester arbiter with registered one-hot grants,
// round-robin or fixed priority, multi-cycle grant lock and a tree-node
// handshake (group_request_OUT / group_grant_IN).
// Optional starvation watchdog is built when ARB_STARVE_WDOG_EN is defined;
// otherwise starve_OUT is tied to zero.
//
// state     | meaning
// ST_IDLE   | no grant outstanding
// ST_GRANT  | one-cycle grant to grant_id_OUT
// ST_LOCKED | grant held for grant_id_OUT under lock_IN
module rr_arbiter_n #(
    parameter int N            = 8,
    parameter int ID_W         = 3,
    parameter int PRIO_MODE    = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic            clock_IN,
    input  logic            reset_IN,
    input  logic [N-1:0]    requests_IN,
    input  logic [N-1:0]    lock_IN,
    input  logic            group_grant_IN,
    output logic            group_request_OUT,
    output logic [N-1:0]    grants_OUT,
    output logic            grant_valid_OUT,
    output logic [ID_W-1:0] grant_id_OUT,
    output logic [N-1:0]    starve_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            valid_q, valid_d;

    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic            hold;
    int              scan_idx;

    assign group_request_OUT = |requests_IN;

    // The current owner keeps the grant only while it both requests and locks.
    assign hold = (state_q != ST_IDLE) && requests_IN[id_q] && lock_IN[id_q];

    // Pick a winner: highest index in fixed mode, first set index from ptr with wrap in RR.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        if (PRIO_MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (requests_IN[i]) begin
                    win_found = 1'b1;
                    win_id    = ID_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                scan_idx = int'(ptr_q) + k;
                if (scan_idx >= N) begin
                    scan_idx = scan_idx - N;
                end
                if (!win_found && requests_IN[scan_idx]) begin
                    win_found = 1'b1;
                    win_id    = ID_W'(scan_idx);
                end
            end
        end
    end

    // Next-state and next-grant selection; parent gating overrides everything.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (!group_grant_IN) begin
            state_d = ST_IDLE;
            grant_d = '0;
            id_d    = '0;
        end else if (hold) begin
            state_d = ST_LOCKED;
        end else if (!win_found) begin
            state_d = ST_IDLE;
            grant_d = '0;
            id_d    = '0;
        end else begin
            state_d         = ST_GRANT;
            grant_d         = '0;
            grant_d[win_id] = 1'b1;
            id_d            = win_id;
            if (PRIO_MODE != 0) begin
                ptr_d = (win_id == ID_W'(N - 1)) ? '0 : win_id + ID_W'(1);
            end
        end
        valid_d = |grant_d;
    end

    // Arbiter state, grant and pointer registers.
    always_ff @(posedge clock_IN or posedge reset_IN) begin
        if (reset_IN) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    assign grants_OUT      = grant_q;
    assign grant_valid_OUT = valid_q;
    assign grant_id_OUT    = id_q;

`ifdef ARB_STARVE_WDOG_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [N-1:0]     starve_q, starve_d;

    // Count cycles a requester waits ungranted; flag when the limit is reached.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (!requests_IN[i] || grant_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(STARVE_LIMIT)) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            starve_d[i] = (cnt_d[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Watchdog counters and flags.
    always_ff @(posedge clock_IN or posedge reset_IN) begin
        if (reset_IN) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            starve_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            starve_q <= starve_d;
        end
    end

    assign starve_OUT = starve_q;
`else
    assign starve_OUT = '0;
`endif

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: a round-robin and a fixed-priority instance share
// the stimulus; a behavioural model is compared every falling edge and
// directed vectors carry literal expectations.
module tb_rr_arbiter_n;

    localparam int LIM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] lock = 4'b0000;
    logic       gg = 1'b1;

    logic       gro_rr, gv_rr, gro_fp, gv_fp;
    logic [3:0] gr_rr, st_rr, gr_fp, st_fp;
    logic [1:0] id_rr, id_fp;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    rr_arbiter_n #(.N(4), .ID_W(2), .PRIO_MODE(1), .STARVE_LIMIT(LIM)) dut_rr (
        .clock_IN(clk), .reset_IN(rst), .requests_IN(req), .lock_IN(lock),
        .group_grant_IN(gg), .group_request_OUT(gro_rr), .grants_OUT(gr_rr),
        .grant_valid_OUT(gv_rr), .grant_id_OUT(id_rr), .starve_OUT(st_rr));

    rr_arbiter_n #(.N(4), .ID_W(2), .PRIO_MODE(0), .STARVE_LIMIT(LIM)) dut_fp (
        .clock_IN(clk), .reset_IN(rst), .requests_IN(req), .lock_IN(lock),
        .group_grant_IN(gg), .group_request_OUT(gro_fp), .grants_OUT(gr_fp),
        .grant_valid_OUT(gv_fp), .grant_id_OUT(id_fp), .starve_OUT(st_fp));

    always #5 clk = ~clk;

    // Model state: index 0 = round-robin instance, 1 = fixed priority.
    int       m_owner [2] = '{-1, -1};
    int       m_ptr   [2] = '{0, 0};
    int       m_cnt   [2][4];
    bit [3:0] m_starve[2] = '{4'b0, 4'b0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input bit [3:0] r, input int ptr, input bit rr);
        bit [7:0] dbl;
        if (r == 4'b0) return -1;
        if (!rr) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end
        dbl = {r, r} >> ptr;
        for (int p = 0; p < 4; p++) if (dbl[p]) return (ptr + p) % 4;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_owner[m] = -1;
                m_ptr[m] = 0;
                m_starve[m] = 4'b0;
                for (int i = 0; i < 4; i++) m_cnt[m][i] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int old;
                old = m_owner[m];
                for (int i = 0; i < 4; i++) begin
                    if (req[i] && old != i) m_cnt[m][i] = (m_cnt[m][i] < LIM) ? m_cnt[m][i] + 1 : LIM;
                    else m_cnt[m][i] = 0;
`ifdef ARB_STARVE_WDOG_EN
                    m_starve[m][i] = (m_cnt[m][i] == LIM);
`else
                    m_starve[m][i] = 1'b0;
`endif
                end
                if (!gg) m_owner[m] = -1;
                else if (old >= 0 && req[old] && lock[old]) m_owner[m] = old;
                else if (req == 4'b0) m_owner[m] = -1;
                else begin
                    m_owner[m] = model_pick(req, m_ptr[m], m == 0);
                    if (m == 0) m_ptr[m] = (m_owner[m] + 1) % 4;
                end
            end
        end
    end

    function automatic logic [3:0] onehot(input int o);
        return (o < 0) ? 4'b0000 : 4'(1 << o);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_rr_grants", gr_rr, onehot(m_owner[0]));
            chk("m_rr_id", id_rr, (m_owner[0] < 0) ? 0 : m_owner[0]);
            chk("m_rr_valid", gv_rr, m_owner[0] >= 0);
            chk("m_rr_starve", st_rr, m_starve[0]);
            chk("m_fp_grants", gr_fp, onehot(m_owner[1]));
            chk("m_fp_id", id_fp, (m_owner[1] < 0) ? 0 : m_owner[1]);
            chk("m_fp_valid", gv_fp, m_owner[1] >= 0);
            chk("m_fp_starve", st_fp, m_starve[1]);
            chk("m_group_req", {gro_rr, gro_fp}, {2{|req}});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_rr(input string nm, input logic [3:0] g, input int id);
        chk({nm, "_rr_grants"}, gr_rr, g);
        chk({nm, "_rr_id"}, id_rr, id);
        chk({nm, "_rr_valid"}, gv_rr, g != 4'b0);
    endtask

    task automatic exp_fp(input string nm, input logic [3:0] g, input int id);
        chk({nm, "_fp_grants"}, gr_fp, g);
        chk({nm, "_fp_id"}, id_fp, id);
        chk({nm, "_fp_valid"}, gv_fp, g != 4'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] wrap_g [5];
        wrap_g[0] = 4'b0001; wrap_g[1] = 4'b0010; wrap_g[2] = 4'b0100;
        wrap_g[3] = 4'b1000; wrap_g[4] = 4'b0001;

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        cmp_en = 1'b1;
        exp_rr("reset", 4'b0000, 0);
        chk("reset_starve", st_rr, 4'b0000);

        // T1: lock index 2, then reset mid-lock
        req = 4'b0100; lock = 4'b0100;
        step(); exp_rr("t1_grant", 4'b0100, 2);
        step(); exp_rr("t1_lock1", 4'b0100, 2);
        step(); exp_rr("t1_lock2", 4'b0100, 2);
        #1; rst = 1'b1;
        #1;
        exp_rr("t1_async", 4'b0000, 0);
        exp_fp("t1_async", 4'b0000, 0);
        req = 4'b1111; lock = 4'b0000;
        #2; rst = 1'b0;

        // T1 release + T2 RR wrap
        for (int i = 0; i < 5; i++) begin
            step();
            exp_rr($sformatf("t2_wrap%0d", i), wrap_g[i], i % 4);
            exp_fp($sformatf("t2_fp%0d", i), 4'b1000, 3);
        end

        // T3 fixed priority
        req = 4'b0110; step(); exp_fp("t3_0110", 4'b0100, 2);
        req = 4'b1010; step(); exp_fp("t3_1010", 4'b1000, 3);
        req = 4'b0000; step(); exp_fp("t3_0000", 4'b0000, 0);
        exp_rr("t3_rr_idle", 4'b0000, 0);

        // T4 lock then release without bubble
        pulse_reset();
        req = 4'b0011; lock = 4'b0001;
        step(); exp_rr("t4_l0", 4'b0001, 0);
        step(); exp_rr("t4_l1", 4'b0001, 0);
        step(); exp_rr("t4_l2", 4'b0001, 0);
        lock = 4'b0000;
        step(); exp_rr("t4_rel", 4'b0010, 1);

        // T5 parent gating with pointer preserved
        req = 4'b1111; gg = 1'b0;
        step(); exp_rr("t5_gate0", 4'b0000, 0); chk("t5_greq0", gro_rr, 1'b1);
        step(); exp_rr("t5_gate1", 4'b0000, 0); chk("t5_greq1", gro_rr, 1'b1);
        gg = 1'b1;
        step(); exp_rr("t5_resume", 4'b0100, 2); chk("t5_greq2", gro_rr, 1'b1);

        // Lock from a non-owner is ignored
        lock = 4'b0001;
        step(); exp_rr("nonowner_lock", 4'b1000, 3);
        lock = 4'b0000;

        // T6 watchdog
        pulse_reset();
        req = 4'b0011; lock = 4'b0001;
        step(); step(); step();
`ifdef ARB_STARVE_WDOG_EN
        chk("t6_starve_set", st_rr, 4'b0010);
`else
        chk("t6_starve_off", st_rr, 4'b0000);
`endif
        lock = 4'b0000;
        step(); exp_rr("t6_rel", 4'b0010, 1);
`ifdef ARB_STARVE_WDOG_EN
        chk("t6_starve_hold", st_rr, 4'b0010);
`else
        chk("t6_starve_off2", st_rr, 4'b0000);
`endif
        step();
        chk("t6_starve_clr", st_rr, 4'b0000);

        req = 4'b0000;
        step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
